ara_cluster_dispatch: RTL and testbench
=======================================

Name: ara_cluster_dispatch

Overview:
- CVA6-side counterpart of the per-cluster accelerator request/response interface of the Ara macros.
- Broadcasts each accelerator request from CVA6 to all NrClusters Ara macros.
- Collects one response per cluster per request and merges them into a single response back to CVA6.
- Bounds in-flight requests and flags response-ordering errors between clusters.

Parameters:
- NrClusters, 4, number of Ara macros served (>=1).
- ReqWidth, 128, request payload bits (instruction, operands, trans id), broadcast unchanged.
- ResultWidth, 64, result bits in a response.
- TransIdWidth, 3, transaction id bits carried in each response.
- MaxOutstanding, 4, maximum requests dispatched but not yet answered (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  CVA6 request valid
- req_ready_o  out  1  CVA6 request ready
- req_data_i  in  ReqWidth  request payload
- clu_req_valid_o  out  NrClusters  per-cluster request valid
- clu_req_ready_i  in  NrClusters  per-cluster request ready
- clu_req_data_o  out  ReqWidth  shared registered request payload
- clu_resp_valid_i  in  NrClusters  per-cluster response valid
- clu_resp_ready_o  out  NrClusters  per-cluster response ready
- clu_result_i  in  NrClusters*ResultWidth  per-cluster result; cluster i at bits [i*ResultWidth +: ResultWidth]
- clu_exc_i  in  NrClusters  per-cluster exception flag
- clu_fflags_i  in  NrClusters*5  per-cluster FP flags
- clu_trans_id_i  in  NrClusters*TransIdWidth  per-cluster transaction id
- clu_store_pending_i  in  NrClusters  per-cluster store pending
- resp_valid_o  out  1  merged response valid
- resp_ready_i  in  1  CVA6 response ready
- resp_result_o  out  ResultWidth  merged result (cluster 0)
- resp_exc_o  out  1  OR of cluster exception flags
- resp_fflags_o  out  5  bitwise OR of cluster fflags
- resp_trans_id_o  out  TransIdWidth  cluster 0 trans id
- store_pending_o  out  1  registered OR of clu_store_pending_i
- outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight request count
- order_err_o  out  1  sticky trans-id mismatch flag

Behaviour:
- Reset (rst_i high at a rising edge):
  - clears broadcast buffer, pending mask, response holds, counter and order_err_o;
  - all outputs 0, except clu_resp_ready_o, which is all-ones;
  - reset mid-operation discards in-flight requests and responses without completing them.
- Broadcast buffer:
  - one entry: buf_valid, buf_data, and a per-cluster pending mask pend[NrClusters].
  - clu_req_valid_o[i] = buf_valid & pend[i]; clu_req_data_o = buf_data.
  - Each cycle pend[i] clears when clu_req_valid_o[i] & clu_req_ready_i[i].
  - Broadcast is done when every pend bit is cleared or clearing this cycle.
  - Clusters may accept in any cycle and order; a cluster never sees the same request twice.
- Upstream acceptance:
  - req_ready_o = (!buf_valid | done_this_cycle) & (count_next_base < MaxOutstanding).
  - count_next_base is the counter after this cycle's response pop.
  - On a request fire: buf_data <= req_data_i, pend <= all ones, buf_valid <= 1.
  - Latency: a request accepted in cycle t is presented to clusters in cycle t+1.
  - Back-to-back requests run at one per cycle when all clusters are ready.
- Response collection:
  - per-cluster hold register with held[i] and captured fields; clu_resp_ready_o[i] = !held[i].
  - resp_valid_o = AND of held.
  - Merge rules:
    - result and trans id come from cluster 0;
    - exc is the OR across clusters;
    - fflags is the bitwise OR across clusters.
  - Merged outputs are valid only while resp_valid_o is high and stay stable until resp_ready_i.
  - Pop on resp_valid_o & resp_ready_i: all held bits clear in the same cycle.
  - A cluster may deliver its next response in the cycle after the pop, not in the pop cycle.
- Order check:
  - at pop, if any held trans id differs from cluster 0's, order_err_o <= 1;
  - it stays set until reset; data is still delivered.
- Outstanding counter:
  - +1 on upstream request fire, -1 on merged response pop; both in the same cycle leaves it unchanged;
  - never exceeds MaxOutstanding and never wraps;
  - a response pop with count 0 is a protocol violation (assertion only).
- store_pending_o is registered: 1-cycle latency from the inputs.
- All arithmetic is unsigned; no combinational path from clu_req_ready_i to clu_req_data_o.

Test Plan:
- Single request, NrClusters=4, all ready:
  - req_data_i=0xABCD accepted at t; clu_req_valid_o=4'b1111 at t+1 with data 0xABCD;
  - outstanding_o=1 at t+2.
- Staggered accept, clusters ready at t+1,t+3,t+2,t+5:
  - each cluster's valid drops after its own accept;
  - req_ready_o low until t+5, high in t+5;
  - no duplicate handshake on any cluster.
- Staggered responses, results 0x11/0x22/0x33/0x44, fflags 1/2/4/8, exc only on cluster 2:
  - resp_valid_o rises after the last arrival;
  - result=0x11, fflags=0xF, exc=1;
  - outstanding_o decrements on pop.
- Back-pressure, MaxOutstanding=4, no responses returned:
  - 4 requests accepted, 5th stalls with req_ready_o=0;
  - one pop re-enables acceptance in that same cycle.
- Trans-id mismatch (cluster 1 returns id 3, others 2):
  - merged id=2 delivered, order_err_o=1 from the cycle after the pop and sticky.
- Reset with 2 outstanding and cluster 0 holding a response:
  - next cycle outstanding_o=0, resp_valid_o=0, clu_req_valid_o=0, clu_resp_ready_o all-ones, order_err_o=0.

Source files
------------

// File: rtl/ara_cluster_dispatch.sv
// CVA6-side dispatcher for the clustered Ara macros: broadcasts each accelerator
// request to every cluster and merges the per-cluster responses into one.
module ara_cluster_dispatch #(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned ResultWidth    = 64,
  parameter int unsigned TransIdWidth   = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [ReqWidth-1:0]                      req_data_i,
  output logic [NrClusters-1:0]                    clu_req_valid_o,
  input  logic [NrClusters-1:0]                    clu_req_ready_i,
  output logic [ReqWidth-1:0]                      clu_req_data_o,
  input  logic [NrClusters-1:0]                    clu_resp_valid_i,
  output logic [NrClusters-1:0]                    clu_resp_ready_o,
  input  logic [NrClusters*ResultWidth-1:0]        clu_result_i,
  input  logic [NrClusters-1:0]                    clu_exc_i,
  input  logic [NrClusters*5-1:0]                  clu_fflags_i,
  input  logic [NrClusters*TransIdWidth-1:0]       clu_trans_id_i,
  input  logic [NrClusters-1:0]                    clu_store_pending_i,
  output logic                                     resp_valid_o,
  input  logic                                     resp_ready_i,
  output logic [ResultWidth-1:0]                   resp_result_o,
  output logic                                     resp_exc_o,
  output logic [4:0]                               resp_fflags_o,
  output logic [TransIdWidth-1:0]                  resp_trans_id_o,
  output logic                                     store_pending_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]      outstanding_o,
  output logic                                     order_err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  // Broadcast buffer
  logic                  buf_valid;
  logic [ReqWidth-1:0]   buf_data;
  logic [NrClusters-1:0] pend;
  logic [NrClusters-1:0] req_hs;
  logic [NrClusters-1:0] pend_left;
  logic                  done_this_cycle;
  logic                  req_fire;

  // Response holds; only cluster 0's result is ever forwarded, so only it is kept
  logic [NrClusters-1:0]                   held;
  logic [NrClusters-1:0]                   held_exc;
  logic [NrClusters-1:0][4:0]              held_fflags;
  logic [NrClusters-1:0][TransIdWidth-1:0] held_tid;
  logic [ResultWidth-1:0]                  held_result0;
  logic [NrClusters-1:0]                   resp_hs;
  logic                                    pop;
  logic                                    tid_mismatch;
  logic [4:0]                              fflags_or;

  logic [CntWidth-1:0] count;
  logic [CntWidth-1:0] count_base;
  logic                order_err;
  logic                store_pending;

  always_comb begin
    clu_req_valid_o = pend & {NrClusters{buf_valid}};
    clu_req_data_o  = buf_data;
    req_hs          = clu_req_valid_o & clu_req_ready_i;
    pend_left       = pend & ~req_hs;
    done_this_cycle = buf_valid & (pend_left == '0);

    resp_valid_o     = &held;
    clu_resp_ready_o = ~held;
    resp_hs          = clu_resp_valid_i & ~held;
    pop              = resp_valid_o & resp_ready_i;

    // Acceptance sees the slot freed by a same-cycle pop
    count_base  = count - CntWidth'(pop);
    req_ready_o = !rst_i & (!buf_valid | done_this_cycle) & (count_base < MaxCnt);
    req_fire    = req_valid_i & req_ready_o;

    fflags_or    = '0;
    tid_mismatch = 1'b0;
    for (int unsigned i = 0; i < NrClusters; i++) begin
      fflags_or = fflags_or | held_fflags[i];
      if (held_tid[i] != held_tid[0]) tid_mismatch = 1'b1;
    end

    resp_result_o   = held_result0;
    resp_exc_o      = |held_exc;
    resp_fflags_o   = fflags_or;
    resp_trans_id_o = held_tid[0];
    store_pending_o = store_pending;
    outstanding_o   = count;
    order_err_o     = order_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid     <= 1'b0;
      buf_data      <= '0;
      pend          <= '0;
      held          <= '0;
      held_exc      <= '0;
      held_fflags   <= '0;
      held_tid      <= '0;
      held_result0  <= '0;
      count         <= '0;
      order_err     <= 1'b0;
      store_pending <= 1'b0;
    end else begin
      assert (!(pop && count == '0));

      if (req_fire) begin
        buf_valid <= 1'b1;
        buf_data  <= req_data_i;
        pend      <= '1;
      end else begin
        buf_valid <= buf_valid & !done_this_cycle;
        pend      <= pend_left;
      end

      for (int unsigned i = 0; i < NrClusters; i++) begin
        if (resp_hs[i]) begin
          held_exc[i]    <= clu_exc_i[i];
          held_fflags[i] <= clu_fflags_i[i*5 +: 5];
          held_tid[i]    <= clu_trans_id_i[i*TransIdWidth +: TransIdWidth];
        end
      end
      if (resp_hs[0]) held_result0 <= clu_result_i[ResultWidth-1:0];
      held <= pop ? '0 : (held | resp_hs);

      if (pop && tid_mismatch) order_err <= 1'b1;

      count         <= count_base + CntWidth'(req_fire);
      store_pending <= |clu_store_pending_i;
    end
  end

  if (NrClusters > 1) begin : g_unused
    logic unused_results;
    assign unused_results = ^clu_result_i[NrClusters*ResultWidth-1:ResultWidth];
  end

endmodule

// File: tb/tb_ara_cluster_dispatch.sv
// Directed bench for ara_cluster_dispatch: request and merged-response
// expectations are queued when stimulus is driven and checked on DUT output.
module tb_ara_cluster_dispatch;

  localparam int unsigned NC = 4;
  localparam int unsigned RW = 64;
  localparam int unsigned TW = 3;
  localparam int unsigned QW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [QW-1:0] req_data;
  logic [NC-1:0] clu_req_valid;
  logic [NC-1:0] clu_req_ready;
  logic [QW-1:0] clu_req_data;
  logic [NC-1:0] clu_resp_valid;
  logic [NC-1:0] clu_resp_ready;
  logic [NC*RW-1:0] clu_result;
  logic [NC-1:0]    clu_exc;
  logic [NC*5-1:0]  clu_fflags;
  logic [NC*TW-1:0] clu_trans_id;
  logic [NC-1:0]    clu_store_pending;
  logic          resp_valid;
  logic          resp_ready;
  logic [RW-1:0] resp_result;
  logic          resp_exc;
  logic [4:0]    resp_fflags;
  logic [TW-1:0] resp_trans_id;
  logic          store_pending;
  logic [2:0]    outstanding;
  logic          order_err;

  typedef struct {
    logic [RW-1:0] result;
    logic          exc;
    logic [4:0]    fflags;
    logic [TW-1:0] tid;
  } resp_t;

  resp_t         resp_q[$];
  logic [QW-1:0] req_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ara_cluster_dispatch #(
    .NrClusters(NC), .ReqWidth(QW), .ResultWidth(RW),
    .TransIdWidth(TW), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .clu_req_valid_o(clu_req_valid), .clu_req_ready_i(clu_req_ready),
    .clu_req_data_o(clu_req_data),
    .clu_resp_valid_i(clu_resp_valid), .clu_resp_ready_o(clu_resp_ready),
    .clu_result_i(clu_result), .clu_exc_i(clu_exc), .clu_fflags_i(clu_fflags),
    .clu_trans_id_i(clu_trans_id), .clu_store_pending_i(clu_store_pending),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_exc_o(resp_exc),
    .resp_fflags_o(resp_fflags), .resp_trans_id_o(resp_trans_id),
    .store_pending_o(store_pending), .outstanding_o(outstanding),
    .order_err_o(order_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_resp(input int i, input logic [RW-1:0] r, input logic e,
                            input logic [4:0] f, input logic [TW-1:0] t);
    clu_result[i*RW +: RW]   = r;
    clu_exc[i]               = e;
    clu_fflags[i*5 +: 5]     = f;
    clu_trans_id[i*TW +: TW] = t;
    clu_resp_valid[i]        = 1'b1;
  endtask

  task automatic expect_bcast(input string tag);
    logic [QW-1:0] d;
    d = req_q.pop_front();
    chk({tag, "_valid"}, clu_req_valid, 4'hF);
    chk({tag, "_data"}, clu_req_data, d);
  endtask

  task automatic check_resp(input string tag);
    resp_t e;
    int unsigned n;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, resp_valid, 1'b1);
    e = resp_q.pop_front();
    chk({tag, "_result"}, resp_result, e.result);
    chk({tag, "_exc"}, resp_exc, e.exc);
    chk({tag, "_fflags"}, resp_fflags, e.fflags);
    chk({tag, "_tid"}, resp_trans_id, e.tid);
  endtask

  task automatic full_resp(input string tag, input logic [RW-1:0] r0,
                           input logic [TW-1:0] t, input logic [NC-1:0] exc_mask);
    for (int i = 0; i < NC; i++) drive_resp(i, r0 + RW'(i), exc_mask[i], 5'(1 << i), t);
    resp_q.push_back('{r0, |exc_mask, 5'h0F, t});
    tick();
    clu_resp_valid = '0;
    check_resp(tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_data = '0; clu_req_ready = '0;
    clu_resp_valid = '0; clu_result = '0; clu_exc = '0; clu_fflags = '0;
    clu_trans_id = '0; clu_store_pending = '0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_clu_req_valid", clu_req_valid, 0);
    chk("rst_clu_resp_ready", clu_resp_ready, 4'hF);
    chk("rst_order_err", order_err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_data", clu_req_data, 0);
    rst = 1'b0;
    tick();

    // Single request, all clusters ready
    clu_req_ready = 4'hF; req_valid = 1'b1; req_data = 128'hABCD;
    #1 chk("t1_req_ready", req_ready, 1);
    req_q.push_back(req_data);
    tick();
    req_valid = 1'b0;
    expect_bcast("t1_bcast");
    tick();
    chk("t1_outstanding", outstanding, 1);
    chk("t1_valid_drop", clu_req_valid, 0);

    // Staggered responses
    drive_resp(1, 64'h22, 1'b0, 5'd2, 3'd5); tick(); clu_resp_valid = '0;
    drive_resp(3, 64'h44, 1'b0, 5'd8, 3'd5); tick(); clu_resp_valid = '0;
    chk("t3_not_yet", resp_valid, 0);
    drive_resp(0, 64'h11, 1'b0, 5'd1, 3'd5); tick(); clu_resp_valid = '0;
    chk("t3_resp_ready_mask", clu_resp_ready, 4'b0100);
    chk("t3_not_yet2", resp_valid, 0);
    drive_resp(2, 64'h33, 1'b1, 5'd4, 3'd5);
    resp_q.push_back('{64'h11, 1'b1, 5'h0F, 3'd5});
    tick(); clu_resp_valid = '0;
    check_resp("t3_merge");
    chk("t3_cnt_before_pop", outstanding, 1);
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    chk("t3_cnt_after_pop", outstanding, 0);
    chk("t3_resp_valid_clear", resp_valid, 0);

    // Staggered accept: cluster ready at t+1, t+3, t+2, t+5
    clu_req_ready = '0; req_valid = 1'b1; req_data = 128'h1234;
    #1 chk("t2_req_ready", req_ready, 1);
    req_q.push_back(req_data);
    tick();
    req_data = 128'h5678; clu_req_ready = 4'b0001;
    #1 chk("t2_req_ready_t1", req_ready, 0);
    expect_bcast("t2_bcast");
    tick();
    chk("t2_valid_t2", clu_req_valid, 4'b1110);
    clu_req_ready = 4'b0101;
    #1 chk("t2_req_ready_t2", req_ready, 0);
    tick();
    chk("t2_valid_t3", clu_req_valid, 4'b1010);
    clu_req_ready = 4'b0111;
    #1 chk("t2_req_ready_t3", req_ready, 0);
    tick();
    chk("t2_valid_t4", clu_req_valid, 4'b1000);
    #1 chk("t2_req_ready_t4", req_ready, 0);
    tick();
    chk("t2_valid_t5", clu_req_valid, 4'b1000);
    clu_req_ready = 4'hF;
    #1 chk("t2_req_ready_t5", req_ready, 1);
    req_q.push_back(req_data);
    tick();
    req_valid = 1'b0;
    expect_bcast("t2_next");
    chk("t2_outstanding", outstanding, 2);
    tick();
    chk("t2_idle", clu_req_valid, 0);

    // Back-pressure: fill to MaxOutstanding
    req_valid = 1'b1; req_data = 128'hA1;
    #1 chk("t4_acc1", req_ready, 1);
    req_q.push_back(req_data);
    tick();
    expect_bcast("t4_b1");
    req_data = 128'hA2;
    #1 chk("t4_acc2", req_ready, 1);
    req_q.push_back(req_data);
    tick();
    expect_bcast("t4_b2");
    req_data = 128'hA3;
    #1 chk("t4_stall", req_ready, 0);
    chk("t4_full", outstanding, 4);
    tick();
    chk("t4_stall2", req_ready, 0);

    // Trans-id mismatch response pops and frees a slot in the same cycle
    drive_resp(0, 64'h55, 1'b0, 5'd1, 3'd2);
    drive_resp(1, 64'h66, 1'b0, 5'd0, 3'd3);
    drive_resp(2, 64'h77, 1'b0, 5'd2, 3'd2);
    drive_resp(3, 64'h88, 1'b0, 5'd0, 3'd2);
    resp_q.push_back('{64'h55, 1'b0, 5'h03, 3'd2});
    tick(); clu_resp_valid = '0;
    check_resp("t5_merge");
    chk("t5_err_before", order_err, 0);
    resp_ready = 1'b1;
    #1 chk("t4_ready_on_pop", req_ready, 1);
    req_q.push_back(req_data);
    tick();
    resp_ready = 1'b0; req_valid = 1'b0;
    chk("t4_cnt_steady", outstanding, 4);
    chk("t5_err_set", order_err, 1);
    chk("t5_resp_clear", resp_valid, 0);
    expect_bcast("t4_b3");
    tick();
    chk("t5_err_sticky", order_err, 1);

    // Drain to 2 outstanding, hold one response on cluster 0, then reset
    full_resp("t6_r1", 64'h100, 3'd1, 4'b0000);
    full_resp("t6_r2", 64'h200, 3'd4, 4'b1000);
    chk("t6_cnt2", outstanding, 2);
    drive_resp(0, 64'h300, 1'b0, 5'd0, 3'd6);
    clu_store_pending = 4'b0100;
    #1 chk("t6_sp_latency", store_pending, 0);
    tick();
    clu_resp_valid = '0;
    chk("t6_sp_set", store_pending, 1);
    chk("t6_held0", clu_resp_ready, 4'b1110);
    rst = 1'b1; clu_store_pending = '0;
    tick();
    chk("t6_rst_cnt", outstanding, 0);
    chk("t6_rst_resp_valid", resp_valid, 0);
    chk("t6_rst_req_valid", clu_req_valid, 0);
    chk("t6_rst_resp_ready", clu_resp_ready, 4'hF);
    chk("t6_rst_order_err", order_err, 0);
    chk("t6_rst_sp", store_pending, 0);
    rst = 1'b0;
    tick();
    chk("t6_post_rst_ready", req_ready, 1);
    chk("sb_empty", resp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
